loopback_fifo: RTL and testbench

LOOPBACK_FIFO -- requirements
Module: loopback_fifo

---
 rtl/loopback_fifo_if.sv | 24 ++
 rtl/loopback_fifo.sv | 146 ++++++++++++++
 tb/tb_loopback_fifo.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/loopback_fifo_if.sv
// AXI-Stream bundle used for every stream port of the loopback FIFO.
// Carries tdata, tkeep, tlast and a one-bit error sideband alongside the handshake.
interface loopback_fifo_if #(
    parameter int DATA_W = 512
);
    localparam int KEEP_W = DATA_W / 8;

    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tlast;
    logic              tuser_err;

    modport master (
        output tvalid, tdata, tkeep, tlast, tuser_err,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tkeep, tlast, tuser_err,
        output tready
    );
endinterface

// File: rtl/loopback_fifo.sv
// Adapter TX stream buffered in a show-ahead FIFO and steered either back to the adapter
// (loopback) or out to the CMAC (passthrough); mode changes only at an idle packet boundary.
module loopback_fifo #(
    parameter int DATA_W = 512,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 32
) (
    input  logic                     cmac_clk,
    input  logic                     rst,
    input  logic                     mode_i,
    loopback_fifo_if.slave           s_axis_adap,
    loopback_fifo_if.master          m_axis_cmac,
    loopback_fifo_if.slave           s_axis_cmac,
    loopback_fifo_if.master          m_axis_adap,
    output logic                     mode_active,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         lb_pkt_cnt,
    output logic [CNT_W-1:0]         err_cnt,
    output logic [CNT_W-1:0]         drop_cnt
);
    localparam int KEEP_W  = DATA_W / 8;
    localparam int AW      = $clog2(DEPTH);
    localparam int PTR_W   = AW + 1;
    localparam int ENTRY_W = DATA_W + KEEP_W + 2;

    typedef logic [ENTRY_W-1:0] entry_t;

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    entry_t            head;
    logic [DATA_W-1:0] head_data;
    logic [KEEP_W-1:0] head_keep;
    logic              head_last;
    logic              head_err;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              out_ready;
    logic              cmac_acc;
    logic              adap_in_pkt;
    logic              cmac_in_pkt;
    logic              mode_ok;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // Extra pointer bit distinguishes full from empty across wrap-around
    assign fifo_level = wr_ptr - rd_ptr;
    assign full       = (fifo_level == PTR_W'(DEPTH));
    assign empty      = (fifo_level == '0);

    assign s_axis_adap.tready = !full;
    assign push      = s_axis_adap.tvalid && !full;
    assign out_ready = mode_active ? m_axis_cmac.tready : m_axis_adap.tready;
    assign pop       = !empty && out_ready;

    assign head      = mem[rd_ptr[AW-1:0]];
    assign head_data = head[ENTRY_W-1 -: DATA_W];
    assign head_keep = head[2 +: KEEP_W];
    assign head_last = head[1];
    assign head_err  = head[0];

    always_ff @(posedge cmac_clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {s_axis_adap.tdata, s_axis_adap.tkeep,
                                    s_axis_adap.tlast, s_axis_adap.tuser_err};
        end
    end

    always_ff @(posedge cmac_clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Output steering; deselected outputs stay all-zero
    always_comb begin
        m_axis_cmac.tvalid    = 1'b0;
        m_axis_cmac.tdata     = '0;
        m_axis_cmac.tkeep     = '0;
        m_axis_cmac.tlast     = 1'b0;
        m_axis_cmac.tuser_err = 1'b0;
        m_axis_adap.tvalid    = 1'b0;
        m_axis_adap.tdata     = '0;
        m_axis_adap.tkeep     = '0;
        m_axis_adap.tlast     = 1'b0;
        m_axis_adap.tuser_err = 1'b0;
        s_axis_cmac.tready    = 1'b1;
        if (mode_active) begin
            m_axis_cmac.tvalid    = !empty;
            m_axis_cmac.tdata     = head_data;
            m_axis_cmac.tkeep     = head_keep;
            m_axis_cmac.tlast     = head_last;
            m_axis_cmac.tuser_err = head_err;
            m_axis_adap.tvalid    = s_axis_cmac.tvalid;
            m_axis_adap.tdata     = s_axis_cmac.tdata;
            m_axis_adap.tkeep     = s_axis_cmac.tkeep;
            m_axis_adap.tlast     = s_axis_cmac.tlast;
            m_axis_adap.tuser_err = s_axis_cmac.tuser_err;
            s_axis_cmac.tready    = m_axis_adap.tready;
        end else begin
            m_axis_adap.tvalid    = !empty;
            m_axis_adap.tdata     = head_data;
            m_axis_adap.tkeep     = head_keep;
            m_axis_adap.tlast     = head_last;
            m_axis_adap.tuser_err = head_err;
        end
    end

    assign cmac_acc = s_axis_cmac.tvalid && s_axis_cmac.tready;
    assign mode_ok  = !adap_in_pkt && !cmac_in_pkt && empty && !push && !cmac_acc;

    always_ff @(posedge cmac_clk or posedge rst) begin
        if (rst) begin
            adap_in_pkt <= 1'b0;
            cmac_in_pkt <= 1'b0;
            mode_active <= 1'b0;
        end else begin
            if (push)     adap_in_pkt <= !s_axis_adap.tlast;
            if (cmac_acc) cmac_in_pkt <= !s_axis_cmac.tlast;
            if (mode_ok)  mode_active <= mode_i;
        end
    end

    always_ff @(posedge cmac_clk or posedge rst) begin
        if (rst) begin
            lb_pkt_cnt <= '0;
            err_cnt    <= '0;
            drop_cnt   <= '0;
        end else begin
            if (pop && head_last && !mode_active)
                lb_pkt_cnt <= sat_inc(lb_pkt_cnt);
            if (pop && head_last && head_err)
                err_cnt <= sat_inc(err_cnt);
            if (cmac_acc && s_axis_cmac.tlast && !mode_active)
                drop_cnt <= sat_inc(drop_cnt);
        end
    end
endmodule

// File: tb/tb_loopback_fifo.sv
// Scoreboard bench for loopback_fifo: expected beats are queued per output stream as they
// are offered and popped when the DUT hands them over.
module tb_loopback_fifo;
    localparam int DW    = 64;
    localparam int KW    = DW / 8;
    localparam int DEPTH = 16;
    localparam int CW    = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          err;
    } beat_t;

    logic          cmac_clk = 1'b0;
    logic          rst;
    logic          mode_i;
    logic          mode_active;
    logic [LW-1:0] fifo_level;
    logic [CW-1:0] lb_pkt_cnt;
    logic [CW-1:0] err_cnt;
    logic [CW-1:0] drop_cnt;

    loopback_fifo_if #(.DATA_W(DW)) s_adap ();
    loopback_fifo_if #(.DATA_W(DW)) m_cmac ();
    loopback_fifo_if #(.DATA_W(DW)) s_cmac ();
    loopback_fifo_if #(.DATA_W(DW)) m_adap ();

    loopback_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .cmac_clk    (cmac_clk),
        .rst         (rst),
        .mode_i      (mode_i),
        .s_axis_adap (s_adap),
        .m_axis_cmac (m_cmac),
        .s_axis_cmac (s_cmac),
        .m_axis_adap (m_adap),
        .mode_active (mode_active),
        .fifo_level  (fifo_level),
        .lb_pkt_cnt  (lb_pkt_cnt),
        .err_cnt     (err_cnt),
        .drop_cnt    (drop_cnt)
    );

    always #5 cmac_clk = ~cmac_clk;

    beat_t q_adap[$];
    beat_t q_cmac[$];
    beat_t obs_a, obs_c, exp_a, exp_c;
    int    vectors     = 0;
    int    miscompares = 0;
    int    cmac_bad    = 0;
    int    exp_lb      = 0;
    int    exp_err     = 0;
    int    exp_drop    = 0;

    // Output monitors: compare every handshake against the scoreboard
    always @(negedge cmac_clk) begin
        if (m_adap.tvalid && m_adap.tready) begin
            vectors++;
            obs_a = {m_adap.tdata, m_adap.tkeep, m_adap.tlast, m_adap.tuser_err};
            if (q_adap.size() == 0) begin
                miscompares++;
                $display("FAIL m_axis_adap unexpected beat got=%h", obs_a);
            end else begin
                exp_a = q_adap.pop_front();
                if (obs_a !== exp_a) begin
                    miscompares++;
                    $display("FAIL m_axis_adap beat got=%h want=%h", obs_a, exp_a);
                end
            end
        end
        if (m_cmac.tvalid && m_cmac.tready) begin
            vectors++;
            obs_c = {m_cmac.tdata, m_cmac.tkeep, m_cmac.tlast, m_cmac.tuser_err};
            if (q_cmac.size() == 0) begin
                miscompares++;
                $display("FAIL m_axis_cmac unexpected beat got=%h", obs_c);
            end else begin
                exp_c = q_cmac.pop_front();
                if (obs_c !== exp_c) begin
                    miscompares++;
                    $display("FAIL m_axis_cmac beat got=%h want=%h", obs_c, exp_c);
                end
            end
        end
        if (!rst && !mode_active && (m_cmac.tvalid || m_cmac.tdata != '0 || m_cmac.tkeep != '0
                                     || m_cmac.tlast || m_cmac.tuser_err))
            cmac_bad++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    function automatic beat_t mk_beat(input logic last, input logic err);
        beat_t b;
        b.data = {$urandom, $urandom};
        b.keep = last ? KW'($urandom_range(1, (1 << KW) - 1)) : '1;
        b.last = last;
        b.err  = err & last;
        return b;
    endfunction

    task automatic drive_adap(input beat_t b);
        s_adap.tvalid    = 1'b1;
        s_adap.tdata     = b.data;
        s_adap.tkeep     = b.keep;
        s_adap.tlast     = b.last;
        s_adap.tuser_err = b.err;
    endtask

    task automatic idle_adap();
        s_adap.tvalid = 1'b0; s_adap.tdata = '0; s_adap.tkeep = '0;
        s_adap.tlast = 1'b0;  s_adap.tuser_err = 1'b0;
    endtask

    task automatic send_adap(input int n, input logic err);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            int    t;
            b = mk_beat(i == n - 1, err);
            if (mode_active) q_cmac.push_back(b); else q_adap.push_back(b);
            drive_adap(b);
            t = 0;
            @(negedge cmac_clk);
            while (!s_adap.tready && t < 200) begin t++; @(negedge cmac_clk); end
            vectors++;
            if (!s_adap.tready) begin
                miscompares++;
                $display("FAIL adap_accept_timeout got tready=%b want 1", s_adap.tready);
            end
            @(posedge cmac_clk); #1;
        end
        idle_adap();
    endtask

    task automatic send_cmac(input int n, input logic err);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            int    t;
            b = mk_beat(i == n - 1, err);
            if (mode_active) q_adap.push_back(b);
            s_cmac.tvalid = 1'b1; s_cmac.tdata = b.data; s_cmac.tkeep = b.keep;
            s_cmac.tlast = b.last; s_cmac.tuser_err = b.err;
            t = 0;
            @(negedge cmac_clk);
            while (!s_cmac.tready && t < 200) begin t++; @(negedge cmac_clk); end
            vectors++;
            if (!s_cmac.tready) begin
                miscompares++;
                $display("FAIL cmac_accept_timeout got tready=%b want 1", s_cmac.tready);
            end
            @(posedge cmac_clk); #1;
        end
        s_cmac.tvalid = 1'b0; s_cmac.tdata = '0; s_cmac.tkeep = '0;
        s_cmac.tlast = 1'b0;  s_cmac.tuser_err = 1'b0;
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((q_adap.size() != 0 || q_cmac.size() != 0 || fifo_level != 0) && t < 500) begin
            @(posedge cmac_clk); #1; t++;
        end
        vectors++;
        if (q_adap.size() != 0 || q_cmac.size() != 0 || fifo_level != 0) begin
            miscompares++;
            $display("FAIL drain got q_adap=%0d q_cmac=%0d level=%0d want 0/0/0",
                     q_adap.size(), q_cmac.size(), fifo_level);
        end
    endtask

    task automatic check_counters(input string tag);
        vectors++;
        if (lb_pkt_cnt !== CW'(exp_lb) || err_cnt !== CW'(exp_err) || drop_cnt !== CW'(exp_drop)) begin
            miscompares++;
            $display("FAIL %s counters got lb=%0d err=%0d drop=%0d want lb=%0d err=%0d drop=%0d",
                     tag, lb_pkt_cnt, err_cnt, drop_cnt, exp_lb, exp_err, exp_drop);
        end
    endtask

    task automatic wait_mode(input logic want);
        int t = 0;
        while (mode_active !== want && t < 10) begin @(posedge cmac_clk); #1; t++; end
        vectors++;
        if (mode_active !== want) begin
            miscompares++;
            $display("FAIL mode_switch got mode_active=%b want %b", mode_active, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; mode_i = 1'b0;
        idle_adap();
        s_cmac.tvalid = 1'b0; s_cmac.tdata = '0; s_cmac.tkeep = '0;
        s_cmac.tlast = 1'b0;  s_cmac.tuser_err = 1'b0;
        m_adap.tready = 1'b0; m_cmac.tready = 1'b0;
        repeat (3) @(posedge cmac_clk);
        #1;
        vectors++;
        if (fifo_level !== '0 || mode_active !== 1'b0 || m_adap.tvalid !== 1'b0
            || m_cmac.tvalid !== 1'b0 || s_adap.tready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state got level=%0d mode=%b adap_v=%b cmac_v=%b s_rdy=%b want 0 0 0 0 1",
                     fifo_level, mode_active, m_adap.tvalid, m_cmac.tvalid, s_adap.tready);
        end
        check_counters("reset");
        rst = 1'b0;
        @(posedge cmac_clk); #1;
    endtask

    task automatic test_basic();
        logic [DW-1:0] first_data;
        m_adap.tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            beat_t b;
            b = mk_beat(i == 2, 1'b0);
            if (i == 0) first_data = b.data;
            q_adap.push_back(b);
            drive_adap(b);
            @(negedge cmac_clk);
            vectors++;
            if (i == 0 && m_adap.tvalid !== 1'b0) begin
                miscompares++;
                $display("FAIL basic_same_cycle got tvalid=%b want 0", m_adap.tvalid);
            end else if (i == 1 && (m_adap.tvalid !== 1'b1 || m_adap.tdata !== first_data)) begin
                miscompares++;
                $display("FAIL basic_latency got tvalid=%b data=%h want 1 %h",
                         m_adap.tvalid, m_adap.tdata, first_data);
            end
            @(posedge cmac_clk); #1;
        end
        idle_adap();
        wait_drain();
        exp_lb = 1;
        check_counters("basic");
    endtask

    task automatic test_full();
        int accepted = 0;
        m_adap.tready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            beat_t b;
            b = mk_beat(i == DEPTH - 1, 1'b0);
            drive_adap(b);
            @(negedge cmac_clk);
            if (s_adap.tready) begin accepted++; q_adap.push_back(b); end
            @(posedge cmac_clk); #1;
        end
        idle_adap();
        vectors++;
        if (accepted != DEPTH || fifo_level !== LW'(DEPTH) || s_adap.tready !== 1'b0) begin
            miscompares++;
            $display("FAIL full got accepted=%0d level=%0d tready=%b want %0d %0d 0",
                     accepted, fifo_level, s_adap.tready, DEPTH, DEPTH);
        end
        m_adap.tready = 1'b1;
        wait_drain();
        exp_lb++;
        check_counters("full");
    endtask

    task automatic test_mode_switch();
        m_adap.tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat_t b;
            b = mk_beat(i == 3, 1'b0);
            q_adap.push_back(b);
            drive_adap(b);
            if (i == 1) mode_i = 1'b1;
            @(negedge cmac_clk);
            vectors++;
            if (mode_active !== 1'b0) begin
                miscompares++;
                $display("FAIL mode_mid_packet got mode_active=%b want 0", mode_active);
            end
            @(posedge cmac_clk); #1;
        end
        idle_adap();
        repeat (3) begin
            @(negedge cmac_clk);
            vectors++;
            if (mode_active !== 1'b0) begin
                miscompares++;
                $display("FAIL mode_fifo_busy got mode_active=%b want 0", mode_active);
            end
        end
        @(posedge cmac_clk); #1;
        m_adap.tready = 1'b1;
        wait_drain();
        exp_lb++;
        wait_mode(1'b1);
        check_counters("mode_switch");
    endtask

    task automatic test_passthrough();
        m_adap.tready = 1'b1;
        m_cmac.tready = 1'b1;
        fork
            send_adap(5, 1'b1);
            send_cmac(3, 1'b0);
        join
        wait_drain();
        exp_err++;
        check_counters("passthrough");
        mode_i = 1'b0;
        wait_mode(1'b0);
    endtask

    task automatic test_err_drop();
        cmac_bad = 0;
        m_adap.tready = 1'b1;
        fork
            begin
                send_cmac(2, 1'b0);
                send_cmac(3, 1'b1);
            end
            send_adap(2, 1'b1);
        join
        wait_drain();
        exp_drop += 2;
        exp_err++;
        exp_lb++;
        check_counters("err_drop");
        vectors++;
        if (cmac_bad != 0) begin
            miscompares++;
            $display("FAIL cmac_idle_in_loopback got %0d active cycles want 0", cmac_bad);
        end
    endtask

    task automatic test_saturation();
        m_adap.tready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            send_adap(1, 1'b0);
            if (exp_lb < (1 << CW) - 1) exp_lb++;
        end
        wait_drain();
        check_counters("saturation");
    endtask

    task automatic test_reset_mid_packet();
        m_adap.tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_adap(mk_beat(1'b0, 1'b0));
            @(posedge cmac_clk); #1;
        end
        idle_adap();
        vectors++;
        if (fifo_level !== LW'(5)) begin
            miscompares++;
            $display("FAIL queued_before_reset got level=%0d want 5", fifo_level);
        end
        rst = 1'b1;
        #1;
        m_adap.tready = 1'b1;
        exp_lb = 0; exp_err = 0; exp_drop = 0;
        vectors++;
        if (fifo_level !== '0 || m_adap.tvalid !== 1'b0 || mode_active !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset got level=%0d adap_v=%b mode=%b want 0 0 0",
                     fifo_level, m_adap.tvalid, mode_active);
        end
        check_counters("during_reset");
        repeat (2) @(posedge cmac_clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge cmac_clk);
        #1;
        vectors++;
        if (fifo_level !== '0) begin
            miscompares++;
            $display("FAIL post_reset_level got %0d want 0", fifo_level);
        end
        send_adap(2, 1'b0);
        wait_drain();
        exp_lb = 1;
        check_counters("post_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_mode_switch();
        test_passthrough();
        test_err_drop();
        test_saturation();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
